// File: rtl/regfile_dump_unit_pkg.sv
// Shared control encodings for the register-dump unit: FSM states, index width
// and the terminal-index helper.
package regfile_dump_unit_pkg;

  localparam int unsigned IDX_W            = 5;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } dump_state_e;

  // Index of the final register scanned; the scan never advances past it.
  function automatic logic [IDX_W-1:0] last_idx(input int unsigned num_regs);
    return IDX_W'(num_regs - 1);
  endfunction

  localparam logic [IDX_W-1:0] DEFAULT_LAST_IDX = last_idx(DEFAULT_NUM_REGS);

endpackage

// File: rtl/regfile_dump_unit.sv
// Scans the register file through a dedicated async read port and streams
// each (index, value) pair over a valid/ready interface with a running checksum.
module regfile_dump_unit
  import regfile_dump_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter bit          SKIP_X0  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [IDX_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [IDX_W-1:0] LAST_IDX  = last_idx(NUM_REGS);
  localparam logic [IDX_W-1:0] FIRST_IDX = SKIP_X0 ? IDX_W'(1) : '0;

  dump_state_e       state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [IDX_W-1:0]  out_idx_q, out_idx_n;
  logic [DATA_W-1:0] out_data_q, out_data_n;
  logic [DATA_W-1:0] checksum_q, checksum_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      checksum_q <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      out_idx_q  <= out_idx_n;
      out_data_q <= out_data_n;
      checksum_q <= checksum_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    out_idx_n  = out_idx_q;
    out_data_n = out_data_q;
    checksum_n = checksum_q;
    unique case (state)
      ST_IDLE: begin
        // start together with abort counts as abort
        if (start && !abort) begin
          state_n    = ST_LOAD;
          idx_n      = FIRST_IDX;
          checksum_n = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else begin
          out_idx_n  = idx;
          out_data_n = rf_data;
          state_n    = ST_SEND;
        end
      end
      ST_SEND: begin
        // abort wins over a handshake in the same cycle: entry is not summed
        if (abort) begin
          state_n = ST_IDLE;
        end else if (out_ready) begin
          checksum_n = checksum_q + out_data_q;
          if (idx == LAST_IDX) begin
            state_n = ST_FIN;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = ST_LOAD;
          end
        end
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign rf_addr   = idx;
  assign out_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  // Gated so an abort landing in FIN suppresses the completion pulse.
  assign done      = (state == ST_FIN) && !abort;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: two instances (SKIP_X0 = 1 and 0)
// backed by a register-file model holding rf[i] = i*3.
module tb_regfile_dump_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, start0, abort, out_ready;
  logic [4:0]  rf_addr, rf_addr0, out_idx, out_idx0;
  logic [31:0] rf_data, rf_data0, out_data, out_data0, checksum, checksum0;
  logic        out_valid, out_valid0, busy, busy0, done, done0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_data  = {27'd0, rf_addr}  * 32'd3;
  assign rf_data0 = {27'd0, rf_addr0} * 32'd3;

  regfile_dump_unit #(.NUM_REGS(32), .SKIP_X0(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  regfile_dump_unit #(.NUM_REGS(32), .SKIP_X0(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort),
    .rf_addr(rf_addr0), .rf_data(rf_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_idx(out_idx0), .out_data(out_data0),
    .busy(busy0), .done(done0), .checksum(checksum0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts one dump and drives it to completion, checking each accepted entry.
  task automatic run_dump(input bit sel0, input int stall_idx, input int abort_idx,
                          input bit spam, output int n_acc, output int n_done,
                          output int gap_err, output int first_valid);
    int          exp_idx;
    int          last_acc;
    int          stall_cnt;
    int          exp_sum;
    bit          fin;
    logic        v, b, d;
    logic [4:0]  ix;
    logic [31:0] dt, cs;
    exp_idx = sel0 ? 0 : 1;
    last_acc = -1; stall_cnt = 0; exp_sum = 0; fin = 1'b0;
    n_acc = 0; n_done = 0; gap_err = 0; first_valid = -1;
    @(negedge clk);
    if (sel0) start0 = 1'b1; else start = 1'b1;
    abort = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0; start0 = 1'b0; abort = 1'b0; out_ready = 1'b1;
      v  = sel0 ? out_valid0 : out_valid;
      b  = sel0 ? busy0      : busy;
      d  = sel0 ? done0      : done;
      ix = sel0 ? out_idx0   : out_idx;
      dt = sel0 ? out_data0  : out_data;
      cs = sel0 ? checksum0  : checksum;
      if (d) n_done++;
      if (!b) begin
        fin = 1'b1;
        break;
      end
      if (spam) begin
        if (sel0) start0 = 1'b1; else start = 1'b1;
      end
      if (v) begin
        if (first_valid < 0) first_valid = c;
        if (int'(ix) == stall_idx && stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
          check("stall_idx", 32'(ix), 32'(stall_idx));
          check("stall_data", dt, 32'(stall_idx * 3));
          check("stall_sum", cs, 32'(exp_sum));
        end else if (int'(ix) == abort_idx) begin
          abort = 1'b1;
        end else begin
          check("entry_idx", 32'(ix), 32'(exp_idx));
          check("entry_data", dt, 32'(exp_idx * 3));
          if (stall_idx < 0 && last_acc >= 0 && c - last_acc != 2) gap_err++;
          last_acc = c;
          exp_sum += exp_idx * 3;
          exp_idx++;
          n_acc++;
        end
      end
    end
    if (!fin) check("dump_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_acc, n_done, gap_err, first_valid;
    bit  found;
    reset_n = 1'b0; start = 1'b0; start0 = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", checksum, 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", 32'(rf_addr), 32'd0);
    reset_n = 1'b1;

    // Full dump, SKIP_X0=1, ready held high
    run_dump(1'b0, -1, -1, 1'b0, n_acc, n_done, gap_err, first_valid);
    check("a_entries", 32'(n_acc), 32'd31);
    check("a_done", 32'(n_done), 32'd1);
    check("a_gap", 32'(gap_err), 32'd0);
    check("a_latency", 32'(first_valid), 32'd1);
    check("a_sum", checksum, 32'd1488);
    repeat (3) @(negedge clk);
    check("a_sum_hold", checksum, 32'd1488);
    check("a_idle_valid", 32'(out_valid), 32'd0);

    // Full dump, SKIP_X0=0
    run_dump(1'b1, -1, -1, 1'b0, n_acc, n_done, gap_err, first_valid);
    check("b_entries", 32'(n_acc), 32'd32);
    check("b_done", 32'(n_done), 32'd1);
    check("b_sum", checksum0, 32'd1488);

    // Backpressure on idx 4
    run_dump(1'b0, 4, -1, 1'b0, n_acc, n_done, gap_err, first_valid);
    check("c_entries", 32'(n_acc), 32'd31);
    check("c_done", 32'(n_done), 32'd1);
    check("c_sum", checksum, 32'd1488);

    // Abort with simultaneous handshake on idx 10
    run_dump(1'b0, -1, 10, 1'b0, n_acc, n_done, gap_err, first_valid);
    check("d_entries", 32'(n_acc), 32'd9);
    check("d_done", 32'(n_done), 32'd0);
    check("d_sum", checksum, 32'd135);
    check("d_valid", 32'(out_valid), 32'd0);

    // start + abort together in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("e_busy", 32'(busy), 32'd0);
    check("e_addr", 32'(rf_addr), 32'd10);
    check("e_sum", checksum, 32'd135);
    @(negedge clk);
    check("e_busy2", 32'(busy), 32'd0);

    // start held high throughout the dump
    run_dump(1'b0, -1, -1, 1'b1, n_acc, n_done, gap_err, first_valid);
    check("f_entries", 32'(n_acc), 32'd31);
    check("f_done", 32'(n_done), 32'd1);
    check("f_gap", 32'(gap_err), 32'd0);
    check("f_sum", checksum, 32'd1488);

    // Asynchronous reset mid-SEND
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_idx == 5'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("g_reach_idx3", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("g_valid", 32'(out_valid), 32'd0);
    check("g_busy", 32'(busy), 32'd0);
    check("g_done", 32'(done), 32'd0);
    check("g_sum", checksum, 32'd0);
    check("g_idx", 32'(out_idx), 32'd0);
    check("g_data", out_data, 32'd0);
    check("g_addr", 32'(rf_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_dump(1'b0, -1, -1, 1'b0, n_acc, n_done, gap_err, first_valid);
    check("g_entries", 32'(n_acc), 32'd31);
    check("g_done_after", 32'(n_done), 32'd1);
    check("g_sum_after", checksum, 32'd1488);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
